// File: rtl/fifobuffer_prog_if.sv
// ============================================================================
// fifobuffer_prog_if : push/pop/status bundle for fifobuffer_prog
// Revision: 1.0
// ============================================================================
`default_nettype none

interface fifobuffer_prog_if #(
   parameter int NUM_BITS = 32,
   parameter int DEPTH    = 8,
   parameter int CNT_W    = $clog2(DEPTH + 1)
) ();

   logic                rd_en;
   logic                wr_en;
   logic [NUM_BITS-1:0] fifo_in;
   logic [NUM_BITS-1:0] fifo_out;
   logic                empty;
   logic                full;
   logic                almost_empty;
   logic                almost_full;
   logic                wr_err;
   logic                rd_err;
   logic [CNT_W-1:0]    fifo_counter;

   modport master (
      output rd_en, wr_en, fifo_in,
      input  fifo_out, empty, full, almost_empty, almost_full,
             wr_err, rd_err, fifo_counter
   );

   modport slave (
      input  rd_en, wr_en, fifo_in,
      output fifo_out, empty, full, almost_empty, almost_full,
             wr_err, rd_err, fifo_counter
   );

endinterface

`default_nettype wire

// File: rtl/fifobuffer_prog.sv
// ============================================================================
// fifobuffer_prog : single-clock FIFO, any DEPTH >= 2, programmable flags.
// Define FIFOBUF_FWFT_EN for first-word-fall-through read; default is registered read.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fifobuffer_prog #(
   parameter int NUM_BITS  = 32,
   parameter int DEPTH     = 8,
   parameter int AFULL_TH  = 6,
   parameter int AEMPTY_TH = 2,
   parameter int CNT_W     = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   fifobuffer_prog_if.slave bus
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [NUM_BITS-1:0] mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]    count;
   logic                is_empty;
   logic                is_full;
   logic                push;
   logic                pop;
   logic                wr_err_q;
   logic                rd_err_q;

   // Explicit compare so non-power-of-two depths wrap correctly.
   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign is_empty = (count == '0);
   assign is_full  = (count == CNT_W'(DEPTH));
   assign push     = bus.wr_en && (!is_full || bus.rd_en);
   assign pop      = bus.rd_en && !is_empty;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         wr_err_q <= 1'b0;
         rd_err_q <= 1'b0;
      end else begin
         wr_err_q <= bus.wr_en && is_full && !bus.rd_en;
         rd_err_q <= bus.rd_en && is_empty;
         if (push) wr_ptr <= next_ptr(wr_ptr);
         if (pop)  rd_ptr <= next_ptr(rd_ptr);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= bus.fifo_in;
   end

`ifdef FIFOBUF_FWFT_EN
   assign bus.fifo_out = mem[rd_ptr];
`else
   logic [NUM_BITS-1:0] out_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)      out_q <= '0;
      else if (pop) out_q <= mem[rd_ptr];
   end

   assign bus.fifo_out = out_q;
`endif

   assign bus.empty        = is_empty;
   assign bus.full         = is_full;
   assign bus.almost_empty = (count <= CNT_W'(AEMPTY_TH));
   assign bus.almost_full  = (count >= CNT_W'(AFULL_TH));
   assign bus.wr_err       = wr_err_q;
   assign bus.rd_err       = rd_err_q;
   assign bus.fifo_counter = count;

endmodule

`default_nettype wire

// File: tb/tb_fifobuffer_prog.sv
// ============================================================================
// tb_fifobuffer_prog : directed bench with read-data scoreboard, DEPTH 8 and 5.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fifobuffer_prog;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fifobuffer_prog_if #(.NUM_BITS(32), .DEPTH(8)) bus8 ();
   fifobuffer_prog_if #(.NUM_BITS(32), .DEPTH(5)) bus5 ();

   fifobuffer_prog #(.NUM_BITS(32), .DEPTH(8), .AFULL_TH(6), .AEMPTY_TH(2)) dut8 (
      .clk (clk),
      .rst (rst),
      .bus (bus8)
   );

   fifobuffer_prog #(.NUM_BITS(32), .DEPTH(5), .AFULL_TH(4), .AEMPTY_TH(1)) dut5 (
      .clk (clk),
      .rst (rst),
      .bus (bus5)
   );

   int n_chk  = 0;
   int n_fail = 0;

   logic [31:0] q8[$];
   logic [31:0] q5[$];
   logic        exp_rd8, exp_rd5;
   logic        fire8, fire5;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic sb_check(input int sel, input logic [31:0] act);
      logic [31:0] e;
      if (sel == 8) begin
         if (q8.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb8_underflow: got 0x%0h expected no read", act);
            return;
         end
         e = q8.pop_front();
         chk("sb8_data", act, e);
      end else begin
         if (q5.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL sb5_underflow: got 0x%0h expected no read", act);
            return;
         end
         e = q5.pop_front();
         chk("sb5_data", act, e);
      end
   endtask

   // Registered read: data is due the cycle after an accepted pop edge.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         fire8 <= 1'b0;
         fire5 <= 1'b0;
      end else begin
         fire8 <= bus8.rd_en && exp_rd8;
         fire5 <= bus5.rd_en && exp_rd5;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
`ifdef FIFOBUF_FWFT_EN
         if (bus8.rd_en && exp_rd8) sb_check(8, bus8.fifo_out);
         if (bus5.rd_en && exp_rd5) sb_check(5, bus5.fifo_out);
`else
         if (fire8) sb_check(8, bus8.fifo_out);
         if (fire5) sb_check(5, bus5.fifo_out);
`endif
      end
   end

   // One clock of stimulus on the selected FIFO; exp_rd marks a pop expected to be accepted.
   task automatic cyc(input int sel, input logic wr, input logic rd,
                      input logic [31:0] din, input logic exp_rd);
      if (sel == 8) begin
         bus8.wr_en = wr; bus8.rd_en = rd; bus8.fifo_in = din; exp_rd8 = exp_rd;
      end else begin
         bus5.wr_en = wr; bus5.rd_en = rd; bus5.fifo_in = din; exp_rd5 = exp_rd;
      end
      @(posedge clk);
      #1;
      bus8.wr_en = 1'b0; bus8.rd_en = 1'b0; bus8.fifo_in = '0; exp_rd8 = 1'b0;
      bus5.wr_en = 1'b0; bus5.rd_en = 1'b0; bus5.fifo_in = '0; exp_rd5 = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      bus8.wr_en = 1'b0; bus8.rd_en = 1'b0; bus8.fifo_in = '0; exp_rd8 = 1'b0;
      bus5.wr_en = 1'b0; bus5.rd_en = 1'b0; bus5.fifo_in = '0; exp_rd5 = 1'b0;
      #2;
      chk("rst_counter", 32'(bus8.fifo_counter), 32'd0);
      chk("rst_empty", 32'(bus8.empty), 32'd1);
      chk("rst_aempty", 32'(bus8.almost_empty), 32'd1);
      chk("rst_full", 32'(bus8.full), 32'd0);
      chk("rst_afull", 32'(bus8.almost_full), 32'd0);
      chk("rst_errs", {30'd0, bus8.wr_err, bus8.rd_err}, 32'd0);
`ifndef FIFOBUF_FWFT_EN
      chk("rst_out", bus8.fifo_out, 32'd0);
`endif
      repeat (2) @(posedge clk);
      #3 rst = 1'b0;

      // Mid-transfer reset discards contents immediately
      for (int k = 1; k <= 3; k++) cyc(8, 1'b1, 1'b0, 32'(k), 1'b0);
      chk("t1_counter3", 32'(bus8.fifo_counter), 32'd3);
      q8.push_back(32'd1);
      cyc(8, 1'b0, 1'b1, 32'd0, 1'b1);
      cyc(8, 1'b0, 1'b0, 32'd0, 1'b0);
      #2 rst = 1'b1;
      #1;
      chk("t1_counter0", 32'(bus8.fifo_counter), 32'd0);
      chk("t1_empty", 32'(bus8.empty), 32'd1);
      chk("t1_aempty", 32'(bus8.almost_empty), 32'd1);
`ifndef FIFOBUF_FWFT_EN
      chk("t1_out", bus8.fifo_out, 32'd0);
`endif
      #3 rst = 1'b0;

      // Fill / overflow / drain / underflow
      for (int k = 1; k <= 8; k++) begin
         cyc(8, 1'b1, 1'b0, 32'(k), 1'b0);
         chk($sformatf("t2_cnt%0d", k), 32'(bus8.fifo_counter), 32'(k));
         chk($sformatf("t2_af%0d", k), 32'(bus8.almost_full), (k >= 6) ? 32'd1 : 32'd0);
         chk($sformatf("t2_full%0d", k), 32'(bus8.full), (k == 8) ? 32'd1 : 32'd0);
         chk($sformatf("t2_ae%0d", k), 32'(bus8.almost_empty), (k <= 2) ? 32'd1 : 32'd0);
      end
      cyc(8, 1'b1, 1'b0, 32'd9, 1'b0);
      chk("t2_wr_err", 32'(bus8.wr_err), 32'd1);
      chk("t2_cnt_ovf", 32'(bus8.fifo_counter), 32'd8);
      cyc(8, 1'b0, 1'b0, 32'd0, 1'b0);
      chk("t2_wr_err_clr", 32'(bus8.wr_err), 32'd0);
      for (int k = 1; k <= 8; k++) begin
         q8.push_back(32'(k));
         cyc(8, 1'b0, 1'b1, 32'd0, 1'b1);
         chk($sformatf("t2_dcnt%0d", k), 32'(bus8.fifo_counter), 32'(8 - k));
      end
      cyc(8, 1'b0, 1'b1, 32'd0, 1'b0);
      chk("t2_rd_err", 32'(bus8.rd_err), 32'd1);
      chk("t2_empty", 32'(bus8.empty), 32'd1);
      cyc(8, 1'b0, 1'b0, 32'd0, 1'b0);
      chk("t2_rd_err_clr", 32'(bus8.rd_err), 32'd0);

      // Wrap on a non-power-of-two depth
      for (int k = 1; k <= 5; k++) cyc(5, 1'b1, 1'b0, 32'(k), 1'b0);
      chk("t3_full5", 32'(bus5.full), 32'd1);
      for (int k = 1; k <= 3; k++) begin
         q5.push_back(32'(k));
         cyc(5, 1'b0, 1'b1, 32'd0, 1'b1);
      end
      for (int k = 6; k <= 8; k++) cyc(5, 1'b1, 1'b0, 32'(k), 1'b0);
      chk("t3_cnt5", 32'(bus5.fifo_counter), 32'd5);
      chk("t3_wr_err", 32'(bus5.wr_err), 32'd0);
      for (int k = 4; k <= 8; k++) begin
         q5.push_back(32'(k));
         cyc(5, 1'b0, 1'b1, 32'd0, 1'b1);
      end
      chk("t3_cnt0", 32'(bus5.fifo_counter), 32'd0);
      chk("t3_empty", 32'(bus5.empty), 32'd1);

      // Simultaneous push+pop while full
      for (int i = 0; i < 8; i++) cyc(8, 1'b1, 1'b0, 32'h100 + 32'(i), 1'b0);
      q8.push_back(32'h100);
      cyc(8, 1'b1, 1'b1, 32'hAA, 1'b1);
      chk("t4_cnt", 32'(bus8.fifo_counter), 32'd8);
      chk("t4_wr_err", 32'(bus8.wr_err), 32'd0);
      chk("t4_full", 32'(bus8.full), 32'd1);
      for (int i = 1; i < 8; i++) begin
         q8.push_back(32'h100 + 32'(i));
         cyc(8, 1'b0, 1'b1, 32'd0, 1'b1);
      end
      q8.push_back(32'hAA);
      cyc(8, 1'b0, 1'b1, 32'd0, 1'b1);
      chk("t4_empty", 32'(bus8.empty), 32'd1);

      // Simultaneous push+pop while empty, then at mid occupancy
      cyc(8, 1'b1, 1'b1, 32'h55, 1'b0);
      chk("t5_cnt1", 32'(bus8.fifo_counter), 32'd1);
      chk("t5_rd_err", 32'(bus8.rd_err), 32'd1);
      q8.push_back(32'h55);
      cyc(8, 1'b1, 1'b1, 32'h66, 1'b1);
      chk("t5_cnt_both", 32'(bus8.fifo_counter), 32'd1);
      chk("t5_rd_err_clr", 32'(bus8.rd_err), 32'd0);
      q8.push_back(32'h66);
      cyc(8, 1'b0, 1'b1, 32'd0, 1'b1);
      chk("t5_cnt0", 32'(bus8.fifo_counter), 32'd0);

      // Read latency of a word written to an empty FIFO
      cyc(8, 1'b1, 1'b0, 32'h11, 1'b0);
`ifdef FIFOBUF_FWFT_EN
      chk("t6_fwft_out", bus8.fifo_out, 32'h11);
      cyc(8, 1'b0, 1'b0, 32'd0, 1'b0);
      chk("t6_fwft_hold", bus8.fifo_out, 32'h11);
`else
      chk("t6_std_hold", bus8.fifo_out, 32'h66);
      cyc(8, 1'b0, 1'b0, 32'd0, 1'b0);
      chk("t6_std_hold2", bus8.fifo_out, 32'h66);
`endif
      q8.push_back(32'h11);
      cyc(8, 1'b0, 1'b1, 32'd0, 1'b1);
      chk("t6_empty", 32'(bus8.empty), 32'd1);

      repeat (2) cyc(8, 1'b0, 1'b0, 32'd0, 1'b0);
      chk("sb8_drained", 32'(q8.size()), 32'd0);
      chk("sb5_drained", 32'(q5.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
